// File: rtl/auto_player.sv
// Automatic song sequencer: walks a combinational note ROM song by song and hands
// each note to a sound engine through a valid/ready handshake, with pause and skip.
module auto_player #(
   parameter int SONG_W    = 3,
   parameter int CNT_W     = 6,
   parameter int NUM_SONGS = 4,
   parameter int OCT_W     = 2,
   parameter int NOTE_W    = 3,
   parameter int LEN_W     = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [SONG_W-1:0] song_sel,
   input  logic [1:0]        mode,
   input  logic              pause,
   input  logic              skip_next,
   input  logic              skip_prev,
   output logic [SONG_W-1:0] rom_song,
   output logic [CNT_W-1:0]  rom_idx,
   input  logic [CNT_W-1:0]  rom_last,
   input  logic [OCT_W-1:0]  rom_oct,
   input  logic [NOTE_W-1:0] rom_note,
   input  logic [LEN_W-1:0]  rom_len,
   output logic              note_valid,
   input  logic              note_ready,
   output logic [OCT_W-1:0]  note_oct,
   output logic [NOTE_W-1:0] note_note,
   output logic [LEN_W-1:0]  note_len,
   input  logic              note_done,
   output logic              note_abort,
   output logic              playing,
   output logic              paused,
   output logic [SONG_W-1:0] cur_song,
   output logic [CNT_W-1:0]  cur_idx
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_ISSUE   = 3'd2,
      ST_WAIT    = 3'd3,
      ST_ADVANCE = 3'd4,
      ST_PAUSED  = 3'd5,
      ST_DONE    = 3'd6
   } state_t;

   localparam logic [SONG_W-1:0] NO_SONG   = {SONG_W{1'b1}};
   localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
   localparam logic [SONG_W-1:0] SONG_ZERO = {SONG_W{1'b0}};
   localparam logic [CNT_W-1:0]  IDX_ZERO  = {CNT_W{1'b0}};

   function automatic logic [SONG_W-1:0] song_after(input logic [SONG_W-1:0] s);
      song_after = (s == LAST_SONG) ? SONG_ZERO : s + SONG_W'(1);
   endfunction

   function automatic logic [SONG_W-1:0] song_before(input logic [SONG_W-1:0] s);
      song_before = (s == SONG_ZERO) ? LAST_SONG : s - SONG_W'(1);
   endfunction

   state_t              state_r, state_s;
   logic [SONG_W-1:0]   cur_song_r, cur_song_s;
   logic [CNT_W-1:0]    cur_idx_r, cur_idx_s;
   logic [OCT_W-1:0]    note_oct_r;
   logic [NOTE_W-1:0]   note_note_r;
   logic [LEN_W-1:0]    note_len_r;
   logic                note_valid_r, playing_r, paused_r;
   logic                load_note_s, abort_s, skip_s, in_note_s;

   // Next-state, next-position and abort decode; en beats skip, skip beats note_done.
   always_comb begin
      state_s     = state_r;
      cur_song_s  = cur_song_r;
      cur_idx_s   = cur_idx_r;
      load_note_s = 1'b0;
      abort_s     = 1'b0;
      skip_s      = skip_next | skip_prev;
      in_note_s   = (state_r == ST_ISSUE) || (state_r == ST_WAIT);

      if (state_r == ST_IDLE) begin
         cur_song_s = song_sel;
         cur_idx_s  = IDX_ZERO;
         if (en && (song_sel != NO_SONG) && (song_sel <= LAST_SONG)) begin
            state_s = ST_FETCH;
         end else begin
            state_s = ST_IDLE;
         end
      end else if (!en) begin
         state_s = ST_IDLE;
         abort_s = in_note_s;
      end else if (skip_s) begin
         cur_song_s = skip_next ? song_after(cur_song_r) : song_before(cur_song_r);
         cur_idx_s  = IDX_ZERO;
         state_s    = ST_FETCH;
         abort_s    = in_note_s;
      end else begin
         case (state_r)
            ST_FETCH: begin
               load_note_s = 1'b1;
               state_s     = ST_ISSUE;
            end
            ST_ISSUE: begin
               if (note_ready) begin
                  state_s = ST_WAIT;
               end else begin
                  state_s = ST_ISSUE;
               end
            end
            ST_WAIT: begin
               if (note_done) begin
                  state_s = pause ? ST_PAUSED : ST_ADVANCE;
               end else begin
                  state_s = ST_WAIT;
               end
            end
            ST_ADVANCE: begin
               if (cur_idx_r < rom_last) begin
                  cur_idx_s = cur_idx_r + CNT_W'(1);
                  state_s   = ST_FETCH;
               end else begin
                  // End of song: mode 11 falls through to play-once behaviour.
                  case (mode)
                     2'b01: begin
                        cur_idx_s = IDX_ZERO;
                        state_s   = ST_FETCH;
                     end
                     2'b10: begin
                        cur_song_s = song_after(cur_song_r);
                        cur_idx_s  = IDX_ZERO;
                        state_s    = ST_FETCH;
                     end
                     default: begin
                        state_s = ST_DONE;
                     end
                  endcase
               end
            end
            ST_PAUSED: begin
               if (!pause) begin
                  state_s = ST_ADVANCE;
               end else begin
                  state_s = ST_PAUSED;
               end
            end
            ST_DONE: begin
               state_s = ST_DONE;
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
   end

   // State, position and status flags, registered from the next-state decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         cur_song_r   <= SONG_ZERO;
         cur_idx_r    <= IDX_ZERO;
         note_valid_r <= 1'b0;
         playing_r    <= 1'b0;
         paused_r     <= 1'b0;
      end else begin
         state_r      <= state_s;
         cur_song_r   <= cur_song_s;
         cur_idx_r    <= cur_idx_s;
         note_valid_r <= (state_s == ST_ISSUE);
         playing_r    <= (state_s == ST_FETCH) || (state_s == ST_ISSUE) ||
                         (state_s == ST_WAIT) || (state_s == ST_ADVANCE) ||
                         (state_s == ST_PAUSED);
         paused_r     <= (state_s == ST_PAUSED);
      end
   end

   // Note fields captured once per FETCH and held through the handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         note_oct_r  <= {OCT_W{1'b0}};
         note_note_r <= {NOTE_W{1'b0}};
         note_len_r  <= {LEN_W{1'b0}};
      end else if (load_note_s) begin
         note_oct_r  <= rom_oct;
         note_note_r <= rom_note;
         note_len_r  <= rom_len;
      end else begin
         note_oct_r  <= note_oct_r;
         note_note_r <= note_note_r;
         note_len_r  <= note_len_r;
      end
   end

   assign rom_song   = cur_song_r;
   assign rom_idx    = cur_idx_r;
   assign cur_song   = cur_song_r;
   assign cur_idx    = cur_idx_r;
   assign note_valid = note_valid_r;
   assign note_oct   = note_oct_r;
   assign note_note  = note_note_r;
   assign note_len   = note_len_r;
   assign playing    = playing_r;
   assign paused     = paused_r;
   // Abort must land in the same cycle as the cancelling skip or en drop.
   assign note_abort = abort_s;

endmodule

// File: tb/tb_auto_player.sv
// Directed bench for auto_player: ROM and sound engine are modelled in the bench,
// expected note fields are derived from the song/index the bench expects.
module tb_auto_player;

   logic       clk = 1'b0;
   logic       rst_n, en, pause, skip_next, skip_prev, note_ready, note_done;
   logic [2:0] song_sel;
   logic [1:0] mode;
   logic [2:0] rom_song;
   logic [5:0] rom_idx, rom_last, last_v;
   logic [1:0] rom_oct;
   logic [2:0] rom_note, rom_len;
   logic       note_valid, note_abort, playing, paused;
   logic [1:0] note_oct;
   logic [2:0] note_note, note_len;
   logic [2:0] cur_song;
   logic [5:0] cur_idx;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // ROM contents: octave = song, note = index, length = index ^ 5.
   assign rom_last = last_v;
   assign rom_oct  = rom_song[1:0];
   assign rom_note = rom_idx[2:0];
   assign rom_len  = rom_idx[2:0] ^ 3'b101;

   auto_player dut (
      .clk(clk), .rst_n(rst_n), .en(en), .song_sel(song_sel), .mode(mode),
      .pause(pause), .skip_next(skip_next), .skip_prev(skip_prev),
      .rom_song(rom_song), .rom_idx(rom_idx), .rom_last(rom_last),
      .rom_oct(rom_oct), .rom_note(rom_note), .rom_len(rom_len),
      .note_valid(note_valid), .note_ready(note_ready),
      .note_oct(note_oct), .note_note(note_note), .note_len(note_len),
      .note_done(note_done), .note_abort(note_abort),
      .playing(playing), .paused(paused), .cur_song(cur_song), .cur_idx(cur_idx)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits for the note to be offered, checks it, accepts it, then finishes it.
   task automatic play_note(input logic [2:0] song, input logic [5:0] idx,
                            input int limit, input bit pause_f);
      int n;
      logic [7:0] exp_fields;
      n = 0;
      while (note_valid !== 1'b1 && n < limit) begin
         tick();
         n++;
      end
      tests++;
      if (note_valid !== 1'b1) begin
         fails++;
         $display("FAIL issue_wait: note_valid=%b after %0d cycles, required 1", note_valid, n);
      end
      tests++;
      if (cur_song !== song || cur_idx !== idx) begin
         fails++;
         $display("FAIL note_pos: song/idx=%0d/%0d, required %0d/%0d", cur_song, cur_idx, song, idx);
      end
      exp_fields = {song[1:0], idx[2:0], idx[2:0] ^ 3'b101};
      tests++;
      if ({note_oct, note_note, note_len} !== exp_fields) begin
         fails++;
         $display("FAIL note_fields: got %h, required %h", {note_oct, note_note, note_len}, exp_fields);
      end
      tick();
      repeat (9) tick();
      note_done = 1'b1;
      pause = pause_f;
      tick();
      note_done = 1'b0;
      if (pause_f) begin
         tests++;
         if (paused !== 1'b1 || note_valid !== 1'b0 || playing !== 1'b1) begin
            fails++;
            $display("FAIL pause_enter: paused=%b valid=%b playing=%b, required 1 0 1", paused, note_valid, playing);
         end
         repeat (3) tick();
         tests++;
         if (paused !== 1'b1 || note_valid !== 1'b0) begin
            fails++;
            $display("FAIL pause_hold: paused=%b valid=%b, required 1 0", paused, note_valid);
         end
         pause = 1'b0;
      end
   endtask

   task automatic go_idle();
      en = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      tests++;
      if ({note_valid, note_abort, playing, paused} !== 4'b0000 ||
          cur_song !== 3'd0 || cur_idx !== 6'd0 || {note_oct, note_note, note_len} !== 8'h00) begin
         fails++;
         $display("FAIL reset_state: v/a/p/ps=%b%b%b%b song=%0d idx=%0d fields=%h, required all 0",
                  note_valid, note_abort, playing, paused, cur_song, cur_idx, {note_oct, note_note, note_len});
      end
   endtask

   task automatic test_play_once();
      mode = 2'b00; song_sel = 3'd1; last_v = 6'd2; note_ready = 1'b1; en = 1'b1;
      play_note(3'd1, 6'd0, 4, 1'b0);
      play_note(3'd1, 6'd1, 4, 1'b0);
      play_note(3'd1, 6'd2, 4, 1'b0);
      tick();
      tests++;
      if (playing !== 1'b0 || note_valid !== 1'b0 || cur_idx !== 6'd2) begin
         fails++;
         $display("FAIL once_done: playing=%b valid=%b idx=%0d, required 0 0 2", playing, note_valid, cur_idx);
      end
      repeat (3) tick();
      tests++;
      if (playing !== 1'b0 || note_valid !== 1'b0) begin
         fails++;
         $display("FAIL done_hold: playing=%b valid=%b, required 0 0", playing, note_valid);
      end
      go_idle();
      tests++;
      if (cur_song !== 3'd1 || cur_idx !== 6'd0 || playing !== 1'b0) begin
         fails++;
         $display("FAIL back_idle: song=%0d idx=%0d playing=%b, required 1 0 0", cur_song, cur_idx, playing);
      end
   endtask

   task automatic test_modes();
      mode = 2'b01; song_sel = 3'd2; last_v = 6'd1; en = 1'b1;
      play_note(3'd2, 6'd0, 4, 1'b0);
      play_note(3'd2, 6'd1, 4, 1'b0);
      play_note(3'd2, 6'd0, 4, 1'b0);
      go_idle();
      mode = 2'b10; song_sel = 3'd3; last_v = 6'd0; en = 1'b1;
      play_note(3'd3, 6'd0, 4, 1'b0);
      tick();
      tests++;
      if (cur_song !== 3'd0 || cur_idx !== 6'd0 || playing !== 1'b1) begin
         fails++;
         $display("FAIL seq_wrap: song=%0d idx=%0d playing=%b, required 0 0 1", cur_song, cur_idx, playing);
      end
      play_note(3'd0, 6'd0, 4, 1'b0);
      go_idle();
      mode = 2'b11; song_sel = 3'd0; last_v = 6'd0; en = 1'b1;
      play_note(3'd0, 6'd0, 4, 1'b0);
      tick();
      tests++;
      if (playing !== 1'b0) begin
         fails++;
         $display("FAIL mode11_once: playing=%b, required 0", playing);
      end
      go_idle();
   endtask

   task automatic test_pause();
      mode = 2'b00; song_sel = 3'd0; last_v = 6'd2; en = 1'b1;
      play_note(3'd0, 6'd0, 4, 1'b0);
      play_note(3'd0, 6'd1, 4, 1'b1);
      play_note(3'd0, 6'd2, 3, 1'b0);
      tick();
      tests++;
      if (playing !== 1'b0) begin
         fails++;
         $display("FAIL pause_end: playing=%b, required 0", playing);
      end
      go_idle();
   endtask

   task automatic test_skip();
      mode = 2'b00; song_sel = 3'd0; last_v = 6'd3; en = 1'b1;
      tick(); tick();
      tick(); tick(); tick();
      skip_prev = 1'b1;
      #1;
      tests++;
      if (note_abort !== 1'b1) begin
         fails++;
         $display("FAIL skip_abort_wait: note_abort=%b, required 1", note_abort);
      end
      tick();
      skip_prev = 1'b0;
      tests++;
      if (cur_song !== 3'd3 || cur_idx !== 6'd0 || note_valid !== 1'b0 || playing !== 1'b1 || note_abort !== 1'b0) begin
         fails++;
         $display("FAIL skip_prev_wrap: song=%0d idx=%0d valid=%b playing=%b abort=%b, required 3 0 0 1 0",
                  cur_song, cur_idx, note_valid, playing, note_abort);
      end
      tick();
      tests++;
      if (note_valid !== 1'b1) begin
         fails++;
         $display("FAIL skip_fetch_issue: note_valid=%b, required 1", note_valid);
      end
      skip_prev = 1'b1;
      #1;
      tests++;
      if (note_abort !== 1'b1) begin
         fails++;
         $display("FAIL skip_abort_issue: note_abort=%b, required 1", note_abort);
      end
      tick();
      skip_prev = 1'b0;
      skip_next = 1'b1;
      skip_prev = 1'b1;
      #1;
      tests++;
      if (cur_song !== 3'd2 || note_abort !== 1'b0) begin
         fails++;
         $display("FAIL skip_fetch: song=%0d abort=%b, required 2 0", cur_song, note_abort);
      end
      tick();
      skip_next = 1'b0;
      skip_prev = 1'b0;
      tests++;
      if (cur_song !== 3'd3) begin
         fails++;
         $display("FAIL skip_both: song=%0d, required 3", cur_song);
      end
      tick(); tick(); tick();
      note_done = 1'b1;
      skip_next = 1'b1;
      tick();
      note_done = 1'b0;
      skip_next = 1'b0;
      tests++;
      if (cur_song !== 3'd0 || cur_idx !== 6'd0) begin
         fails++;
         $display("FAIL skip_vs_done: song=%0d idx=%0d, required 0 0", cur_song, cur_idx);
      end
      tick();
      tests++;
      if (note_valid !== 1'b1 || cur_idx !== 6'd0) begin
         fails++;
         $display("FAIL skip_no_advance: valid=%b idx=%0d, required 1 0", note_valid, cur_idx);
      end
      go_idle();
   endtask

   task automatic test_en_drop();
      note_ready = 1'b0; song_sel = 3'd1; mode = 2'b00; last_v = 6'd2; en = 1'b1;
      tick(); tick();
      note_done = 1'b1;
      tick();
      note_done = 1'b0;
      tests++;
      if (note_valid !== 1'b1 || cur_idx !== 6'd0) begin
         fails++;
         $display("FAIL done_outside_wait: valid=%b idx=%0d, required 1 0", note_valid, cur_idx);
      end
      en = 1'b0;
      skip_next = 1'b1;
      #1;
      tests++;
      if (note_abort !== 1'b1) begin
         fails++;
         $display("FAIL en_drop_abort: note_abort=%b, required 1", note_abort);
      end
      tick();
      skip_next = 1'b0;
      tests++;
      if (note_valid !== 1'b0 || playing !== 1'b0 || note_abort !== 1'b0 || cur_song !== 3'd1) begin
         fails++;
         $display("FAIL en_drop_idle: valid=%b playing=%b abort=%b song=%0d, required 0 0 0 1",
                  note_valid, playing, note_abort, cur_song);
      end
      song_sel = 3'd7; en = 1'b1;
      repeat (3) tick();
      skip_next = 1'b1;
      tick();
      skip_next = 1'b0;
      tick();
      tests++;
      if (playing !== 1'b0 || cur_song !== 3'd7) begin
         fails++;
         $display("FAIL no_song_idle: playing=%b song=%0d, required 0 7", playing, cur_song);
      end
      song_sel = 3'd4;
      tick(); tick();
      tests++;
      if (playing !== 1'b0 || cur_song !== 3'd4) begin
         fails++;
         $display("FAIL bad_song_idle: playing=%b song=%0d, required 0 4", playing, cur_song);
      end
      go_idle();
      note_ready = 1'b1;
   endtask

   task automatic test_reset_mid();
      song_sel = 3'd1; last_v = 6'd2; mode = 2'b00; en = 1'b1;
      tick(); tick(); tick(); tick();
      #3;
      rst_n = 1'b0;
      #1;
      tests++;
      if ({note_valid, note_abort, playing, paused} !== 4'b0000 ||
          cur_song !== 3'd0 || cur_idx !== 6'd0 || {note_oct, note_note, note_len} !== 8'h00) begin
         fails++;
         $display("FAIL reset_mid: v/a/p/ps=%b%b%b%b song=%0d idx=%0d fields=%h, required all 0",
                  note_valid, note_abort, playing, paused, cur_song, cur_idx, {note_oct, note_note, note_len});
      end
      en = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; pause = 1'b0; skip_next = 1'b0; skip_prev = 1'b0;
      note_ready = 1'b1; note_done = 1'b0; song_sel = 3'd0; mode = 2'b00; last_v = 6'd0;
      #12;
      test_reset();
      rst_n = 1'b1;
      tick();
      test_play_once();
      test_modes();
      test_pause();
      test_skip();
      test_en_drop();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
